// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter:
// ALU control codes and the arbiter state encoding.
package alu_arbiter_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both requesters.
// Unknown control codes fall through to ADD.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] first_operand,
  input  logic [DATA_W-1:0] second_operand,
  input  logic [3:0]        ALU_Control,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = first_operand + second_operand;
    unique case (1'b1)
      (ALU_Control == OP_AND):
        result = first_operand & second_operand;
      (ALU_Control == OP_OR):
        result = first_operand | second_operand;
      (ALU_Control == OP_SUB):
        result = first_operand - second_operand;
      (ALU_Control == OP_NOR):
        result = ~(first_operand | second_operand);
      default: ;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two
// valid/ready requesters, with registered responses.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  state_t              state_q;
  logic                owner_q;
  logic                last_q;
  logic [3:0]          op_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]   res_q;
  logic                zero_q;
  logic                v0_q;
  logic                v1_q;
  logic                busy_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                any_d;
  logic                gnt_d;
  logic                idle;
  logic                handoff;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_zero;

  alu_arbiter_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .first_operand (a_q),
    .second_operand(b_q),
    .ALU_Control   (op_q),
    .result        (alu_res),
    .zero          (alu_zero)
  );

  // gnt_d: 1 selects port 1; ties go to the port not granted last
  always_comb begin
    any_d = req0_valid | req1_valid;
    gnt_d = req1_valid;
    if (req0_valid & req1_valid)
      gnt_d = ~last_q;
  end

  assign idle    = (state_q == IDLE);
  assign handoff = (state_q == RESP) &
                   ((v0_q & rsp0_ready) |
                    (v1_q & rsp1_ready));

  assign req0_ready = idle & req0_valid & ~gnt_d;
  assign req1_ready = idle & req1_valid & gnt_d;

  always_comb
    assert (alu_zero == (alu_res == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_d) begin
            op_q    <= gnt_d ? req1_op : req0_op;
            a_q     <= gnt_d ? req1_a : req0_a;
            b_q     <= gnt_d ? req1_b : req0_b;
            owner_q <= gnt_d;
            last_q  <= gnt_d;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          res_q   <= alu_res;
          zero_q  <= (alu_res == '0);
          v0_q    <= ~owner_q;
          v1_q    <= owner_q;
          state_q <= RESP;
        end
        RESP: begin
          if (handoff) begin
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
            if (cnt_q != '1)
              cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp0_valid = v0_q;
  assign rsp1_valid = v1_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign busy       = busy_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter, built with a
// narrow op counter so saturation is reachable.
module tb_alu_arbiter;

  localparam int DW   = 32;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready;
  logic [3:0]    req0_op;
  logic [DW-1:0] req0_a, req0_b;
  logic          rsp0_valid, rsp0_ready;
  logic          req1_valid, req1_ready;
  logic [3:0]    req1_op;
  logic [DW-1:0] req1_a, req1_b;
  logic          rsp1_valid, rsp1_ready;
  logic [DW-1:0] rsp_result;
  logic          rsp_zero;
  logic          busy;
  logic [CW-1:0] op_count;

  int n_chk = 0;
  int n_err = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  alu_arbiter #(
    .DATA_W(DW),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_op   (req0_op),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .rsp0_valid(rsp0_valid),
    .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_op   (req1_op),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .rsp1_valid(rsp1_valid),
    .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result),
    .rsp_zero  (rsp_zero),
    .busy      (busy),
    .op_count  (op_count)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic bump;
    if (exp_cnt != CMAX) exp_cnt++;
  endtask

  task automatic drive(input int p, input logic [3:0] op,
                       input logic [DW-1:0] a,
                       input logic [DW-1:0] b);
    if (p == 0) begin
      req0_valid = 1'b1; req0_op = op;
      req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op;
      req1_a = a; req1_b = b;
    end
  endtask

  // Starts and ends at a negedge with the DUT idle and rsp ready high
  task automatic run_op(input string tag, input int p,
                        input logic [3:0] op,
                        input logic [DW-1:0] a,
                        input logic [DW-1:0] b,
                        input logic [DW-1:0] er,
                        input logic ez);
    @(negedge clk);
    drive(p, op, a, b);
    #1;
    chk({tag, "/rdy"}, (p == 0) ? req0_ready : req1_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk({tag, "/busy"}, busy, 1);
    @(negedge clk);
    chk({tag, "/v0"}, rsp0_valid, (p == 0));
    chk({tag, "/v1"}, rsp1_valid, (p == 1));
    chk({tag, "/res"}, rsp_result, er);
    chk({tag, "/zero"}, rsp_zero, ez);
    @(negedge clk);
    bump();
    chk({tag, "/cnt"}, op_count, exp_cnt);
    chk({tag, "/idle"}, busy, 0);
  endtask

  initial begin
    int grants, rsps, want;
    bit drop;
    rst = 1'b1;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst/busy", busy, 0);
    chk("rst/v0", rsp0_valid, 0);
    chk("rst/v1", rsp1_valid, 0);
    chk("rst/cnt", op_count, 0);
    chk("rst/res", rsp_result, 0);
    chk("rst/zero", rsp_zero, 0);
    rst = 1'b0;

    run_op("add", 0, 4'b0010, 5, 7, 12, 0);
    run_op("subz", 1, 4'b0110, 32'h1234, 32'h1234, 0, 1);

    // Contention: last grant was port 1, so port 0 leads
    drive(0, 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    drive(1, 4'b1100, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    grants = 0; rsps = 0; want = 0; drop = 0;
    for (int c = 0; c < 40 && rsps < 4; c++) begin
      if (drop) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      #1;
      if (req0_ready | req1_ready) begin
        chk("cont/gnt", req1_ready, want);
        chk("cont/one", req0_ready & req1_ready, 0);
        want = 1 - want;
        grants++;
        if (grants == 4) drop = 1;
      end
      if (rsp0_valid) begin
        chk("cont/r0", rsp_result, 32'h00F0_00F0);
        rsps++; bump();
      end
      if (rsp1_valid) begin
        chk("cont/r1", rsp_result, 32'h000F_000F);
        rsps++; bump();
      end
      @(negedge clk);
    end
    chk("cont/done", rsps, 4);
    chk("cont/cnt", op_count, exp_cnt);

    // Backpressure on port 0 with port 1 waiting
    rsp0_ready = 1'b0;
    @(negedge clk);
    drive(0, 4'b0001, 1, 2);
    @(negedge clk);
    req0_valid = 1'b0;
    drive(1, 4'b0010, 10, 20);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp/v0", rsp0_valid, 1);
      chk("bp/res", rsp_result, 3);
      chk("bp/r1", req1_ready, 0);
      chk("bp/busy", busy, 1);
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    bump();
    #1;
    chk("bp/idle", busy, 0);
    chk("bp/cnt", op_count, exp_cnt);
    chk("bp/late", req1_ready, 1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    chk("bp/v1", rsp1_valid, 1);
    chk("bp/res1", rsp_result, 30);
    @(negedge clk);
    bump();
    chk("sat/cnt", op_count, exp_cnt);

    // Reset while in EXEC
    drive(1, 4'b0010, 1, 1);
    @(negedge clk);
    req1_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    chk("mrst/busy", busy, 0);
    chk("mrst/v0", rsp0_valid, 0);
    chk("mrst/v1", rsp1_valid, 0);
    chk("mrst/cnt", op_count, 0);
    drive(0, 4'b0010, 2, 3);
    drive(1, 4'b0010, 4, 5);
    #1;
    chk("mrst/g0", req0_ready, 1);
    chk("mrst/g1", req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("mrst/v", rsp0_valid, 1);
    chk("mrst/res", rsp_result, 5);
    @(negedge clk);
    bump();
    chk("mrst/cnt1", op_count, exp_cnt);

    run_op("wrap", 0, 4'b0010, 32'hFFFF_FFFF, 1, 0, 1);
    run_op("op7", 1, 4'b0111, 3, 4, 7, 0);
    run_op("opF", 0, 4'b1111, 32'h8000_0000, 32'h8000_0001, 1, 0);
    run_op("nor", 1, 4'b1100, 0, 0, 32'hFFFF_FFFF, 0);
    for (int i = 0; i < 5; i++)
      run_op("fill", i % 2, 4'b0110, i, 1, i - 1, (i == 1));
    chk("sat/max", op_count, CMAX);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
